// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arb
//  Purpose  : Round-robin arbiter feeding an 8-bit UART transmitter.
//             Optional even parity symbol enabled by macro UART_TX_PARITY_EN.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arb #(
    parameter int NREQ      = 4,
    parameter int STOP_BITS = 1
) (
    input  logic                    clki,
    input  logic                    rst_n,
    input  logic                    txd_ena,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    txd,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int IDW = $clog2(NREQ);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        STOP   = 3'd5
    } state_t;
`endif

    state_t           state_q, state_d;
    logic             txd_q, txd_d;
    logic [7:0]       byte_q, byte_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             stop_q, stop_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   gid_q, gid_d;

    logic             found_hi, found_lo;
    logic [IDW-1:0]   idx_hi, idx_lo, win_idx;

    // Two-pass search: lowest valid index at or above the pointer wins,
    // otherwise the lowest valid index below it (wrap-around).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (i >= int'(ptr_q)) begin
                    found_hi = 1'b1;
                    idx_hi   = IDW'(i);
                end else begin
                    found_lo = 1'b1;
                    idx_lo   = IDW'(i);
                end
            end
        end
        win_idx = found_hi ? idx_hi : idx_lo;
    end

    always_comb begin
        state_d   = state_q;
        txd_d     = txd_q;
        byte_d    = byte_q;
        cnt_d     = cnt_q;
        stop_d    = stop_q;
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        req_ready = '0;

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                // Ready is gated by rst_n so nothing is offered while held in reset.
                if (rst_n && (found_hi || found_lo)) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (IDW'(i) == win_idx) begin
                            req_ready[i] = 1'b1;
                            byte_d       = req_data[8*i +: 8];
                        end
                    end
                    gid_d   = win_idx;
                    ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (txd_ena) begin
                    txd_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (txd_ena) begin
                    txd_d   = byte_q[0];
                    cnt_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (txd_ena) begin
                    if (cnt_q != 3'd7) begin
                        txd_d = byte_q[cnt_q + 3'd1];
                        cnt_d = cnt_q + 3'd1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = ^byte_q;
                        state_d = PARITY;
`else
                        txd_d   = 1'b1;
                        stop_d  = 1'b0;
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (txd_ena) begin
                    txd_d   = 1'b1;
                    stop_d  = 1'b0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (txd_ena) begin
                    if (int'(stop_q) == STOP_BITS - 1) begin
                        stop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            txd_q   <= 1'b1;
            byte_q  <= 8'h00;
            cnt_q   <= 3'd0;
            stop_q  <= 1'b0;
            ptr_q   <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            txd_q   <= txd_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
        end
    end

    assign txd      = txd_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = gid_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arb
//  Purpose  : Symbol-queue reference model plus directed and random stimulus.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_arb;

    localparam int NREQ = 4;
    localparam int SB   = 2;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int S0 = 17 + 16 * (9 + PAR);

    logic              clki = 1'b0;
    logic              rst_n = 1'b0;
    logic              txd_ena = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              txd;
    logic              busy;
    logic [1:0]        grant_id;

    int checks = 0;
    int errors = 0;
    int ena_mode = 0;
    int ena_cnt = 0;

    logic            log_txd  [0:319];
    logic            log_busy [0:319];
    logic [NREQ-1:0] log_rdy  [0:319];

    uart_tx_arb #(.NREQ(NREQ), .STOP_BITS(SB)) dut (
        .clki      (clki),
        .rst_n     (rst_n),
        .txd_ena   (txd_ena),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .txd       (txd),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial forever #5 clki = ~clki;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a frame is a queue of line symbols, one popped per strobe.
    bit   m_busy;
    bit   m_line;
    int   m_ptr;
    int   m_gid;
    bit   m_q[$];

    function automatic void m_reset();
        m_busy = 1'b0;
        m_line = 1'b1;
        m_ptr  = 0;
        m_gid  = 0;
        m_q.delete();
    endfunction

    function automatic int winner(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    initial begin
        int w;
        logic [7:0] b;
        m_reset();
        forever begin
            @(posedge clki or negedge rst_n);
            if (!rst_n) begin
                m_reset();
            end else if (!m_busy) begin
                w = winner(req_valid, m_ptr);
                if (w >= 0) begin
                    b     = req_data[8*w +: 8];
                    m_gid = w;
                    m_ptr = (w + 1) % NREQ;
                    m_q.delete();
                    m_q.push_back(1'b0);
                    for (int i = 0; i < 8; i++) m_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
                    m_q.push_back(^b);
`endif
                    for (int i = 0; i < SB; i++) m_q.push_back(1'b1);
                    m_busy = 1'b1;
                end
            end else if (txd_ena) begin
                if (m_q.size() > 0) m_line = m_q.pop_front();
                else m_busy = 1'b0;
            end
        end
    end

    initial begin
        int w;
        logic [NREQ-1:0] exp_rdy;
        forever begin
            @(negedge clki);
            exp_rdy = '0;
            if (rst_n && !m_busy) begin
                w = winner(req_valid, m_ptr);
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            chk("model_txd", int'(txd), int'(m_line));
            chk("model_busy", int'(busy), int'(m_busy));
            chk("model_grant_id", int'(grant_id), m_gid);
            chk("model_req_ready", int'(req_ready), int'(exp_rdy));
        end
    end

    task automatic tick();
        @(posedge clki);
        #1;
        if (ena_mode == 0) begin
            ena_cnt = (ena_cnt + 1) % 16;
            txd_ena = (ena_cnt == 0);
        end else begin
            txd_ena = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic do_reset();
        tick();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Returns with txd_ena just raised for the current cycle.
    task automatic align_strobe();
        for (int i = 0; i < 17 && ena_cnt != 15; i++) tick();
        tick();
    endtask

    // Cycle 0 of the log is the grant cycle, which coincides with a strobe.
    task automatic run_frame(input int r, input logic [7:0] b, input int ncyc);
        align_strobe();
        req_valid         = '0;
        req_valid[r]      = 1'b1;
        req_data[8*r +: 8] = b;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clki);
            log_txd[c]  = txd;
            log_busy[c] = busy;
            log_rdy[c]  = req_ready;
            tick();
            if (c == 0) req_valid = '0;
            for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = 8'($urandom);
        end
    endtask

    initial begin
        logic exp_a5 [0:11];
        int   cnt, ngr, ngid, dens, last;
        int   grants [0:4];
        int   gids   [0:4];
        bit   want_gid;

        exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset with every requester asserting: nothing may be offered.
        req_valid = '1;
        tick(); tick(); tick();
        @(negedge clki);
        chk("rst_txd", int'(txd), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        tick();
        req_valid = '0;
        rst_n     = 1'b1;

        // Single 0xA5 from requester 0, strobe coincident with the grant.
        run_frame(0, 8'hA5, S0 + 48);
        chk("a5_strobe_ignored_c1", int'(log_txd[1]), 1);
        chk("a5_armed_c16", int'(log_txd[16]), 1);
        for (int k = 0; k < 10 + PAR; k++)
            chk($sformatf("a5_symbol%0d", k), int'(log_txd[17 + 16*k + 8]), int'(exp_a5[k + (PAR == 0 && k == 9 ? 1 : 0)]));
        cnt = 0;
        for (int c = S0; c < S0 + 40; c++) if (log_txd[c] && log_busy[c]) cnt++;
        chk("a5_stop_len", cnt, 32);
        chk("a5_busy_end", int'(log_busy[S0 + 31]), 1);
        chk("a5_busy_fall", int'(log_busy[S0 + 32]), 0);
        cnt = 0;
        last = 0;
        for (int c = 0; c < S0 + 48; c++) begin
            if (log_rdy[c][0]) cnt++;
            if (log_rdy[c][NREQ-1:1] != '0) last++;
        end
        chk("a5_ready0_pulses", cnt, 1);
        chk("a5_other_ready", last, 0);
        chk("a5_grant_id", int'(grant_id), 0);

`ifdef UART_TX_PARITY_EN
        run_frame(1, 8'h07, S0 + 48);
        chk("par07", int'(log_txd[17 + 16*9 + 8]), 1);
        run_frame(2, 8'h03, S0 + 48);
        chk("par03", int'(log_txd[17 + 16*9 + 8]), 0);
`endif

        // All requesters held: strict rotation from index 0.
        do_reset();
        req_valid = '1;
        req_data  = 32'h44332211;
        ngr = 0; ngid = 0; want_gid = 0;
        for (int c = 0; c < 3000 && ngid < 5; c++) begin
            @(negedge clki);
            if (want_gid) begin
                gids[ngid] = int'(grant_id);
                ngid++;
                want_gid = 0;
            end
            if (req_ready != '0 && ngr < 5) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants[ngr] = i;
                ngr++;
                want_gid = 1;
            end
            tick();
        end
        chk("rr_grant_count", ngid, 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_order%0d", k), (k < ngr) ? grants[k] : -1, k % 4);
            chk($sformatf("rr_gid%0d", k), (k < ngid) ? gids[k] : -1, k % 4);
        end
        req_valid = '0;
        for (int c = 0; c < 400 && busy; c++) tick();

        // Reset in the middle of data bit 4 of 0x3C, req2 pending.
        do_reset();
        align_strobe();
        req_valid     = 4'b0001;
        req_data[7:0] = 8'h3C;
        for (int c = 0; c < 104; c++) begin
            @(negedge clki);
            if (c == 103) begin
                chk("mid_busy", int'(busy), 1);
                chk("mid_bit4", int'(txd), 1);
            end
            tick();
            if (c == 0) begin
                req_valid       = 4'b0100;
                req_data[23:16] = 8'h5A;
            end
        end
        rst_n = 1'b0;
        @(negedge clki);
        chk("abort_txd", int'(txd), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(req_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clki);
        chk("post_rst_ready", int'(req_ready), 4);
        tick();
        req_valid = '0;
        @(negedge clki);
        chk("post_rst_gid", int'(grant_id), 2);
        for (int c = 0; c < 400 && busy; c++) begin
            tick();
            @(negedge clki);
        end
        chk("post_rst_frame_done", int'(busy), 0);

        // Random traffic, random strobes, occasional one-cycle resets.
        for (int blk = 0; blk < 24; blk++) begin
            ena_mode = (blk % 3 == 2) ? 0 : 1;
            dens     = $urandom_range(0, 4);
            for (int c = 0; c < 800; c++) begin
                tick();
                rst_n = ($urandom_range(0, 1999) != 0);
                for (int i = 0; i < NREQ; i++) begin
                    req_valid[i]       = ($urandom_range(0, 3) < dens);
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
        end
        rst_n     = 1'b1;
        req_valid = '0;
        ena_mode  = 1;
        for (int c = 0; c < 400 && busy; c++) tick();
        @(negedge clki);
        chk("final_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
